impix_tile_sequencer: RTL and testbench



---
 rtl/impix_pkg.sv | 51 +++++
 rtl/impix_tile_walker.sv | 75 +++++++
 rtl/impix_tile_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_impix_tile_sequencer.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/impix_pkg.sv
`default_nettype none
// ============================================================================
// Module      : impix_pkg
// Description : Shared types and constants for the pixelization tile sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package impix_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_ISSUE = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [2:0] c_ADDR_CTRL   = 3'd0;
    localparam logic [2:0] c_ADDR_STATUS = 3'd1;
    localparam logic [2:0] c_ADDR_IMG_W  = 3'd2;
    localparam logic [2:0] c_ADDR_IMG_H  = 3'd3;
    localparam logic [2:0] c_ADDR_BLK    = 3'd4;
    localparam logic [2:0] c_ADDR_TILES  = 3'd5;
    localparam logic [2:0] c_ADDR_OUTST  = 3'd6;

    localparam int c_CTRL_START  = 0;
    localparam int c_CTRL_ABORT  = 1;
    localparam int c_CTRL_USE_SW = 2;
    localparam int c_CTRL_IRQ_EN = 3;

    localparam int c_STAT_BUSY    = 0;
    localparam int c_STAT_DONE    = 1;
    localparam int c_STAT_ABORTED = 2;
    localparam int c_STAT_ERR     = 3;

    localparam logic [2:0] c_BLK_MIN = 3'd1;
    localparam logic [2:0] c_BLK_MAX = 3'd6;

    // Block size is stored as log2; anything outside 1..6 saturates.
    function automatic logic [2:0] clamp_log2(input logic [31:0] v);
        logic [2:0] r;
        if (v < {29'd0, c_BLK_MIN})
            r = c_BLK_MIN;
        else if (v > {29'd0, c_BLK_MAX})
            r = c_BLK_MAX;
        else
            r = v[2:0];
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/impix_tile_walker.sv
`default_nettype none
// ============================================================================
// Module      : impix_tile_walker
// Description : Raster-order tile origin counters with edge clipping.
// Revision    : 1.0 - initial release
// ============================================================================
module impix_tile_walker #(
    parameter int DIM_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_init,
    input  logic             i_step,
    input  logic [2:0]       i_size_log2,
    input  logic [DIM_W-1:0] i_img_w,
    input  logic [DIM_W-1:0] i_img_h,
    output logic [DIM_W-1:0] o_x,
    output logic [DIM_W-1:0] o_y,
    output logic [6:0]       o_w,
    output logic [6:0]       o_h,
    output logic             o_last
);
    import impix_pkg::*;

    logic [DIM_W-1:0] r_x;
    logic [DIM_W-1:0] r_y;
    logic [6:0]       r_size;

    logic [DIM_W:0]   w_size_ext;
    logic [DIM_W-1:0] w_size_dim;
    logic [DIM_W:0]   w_rem_w;
    logic [DIM_W:0]   w_rem_h;
    logic [DIM_W:0]   w_x_end;
    logic [DIM_W:0]   w_y_end;
    logic             w_x_edge;
    logic             w_y_edge;

    assign w_size_ext = {{(DIM_W-6){1'b0}}, r_size};
    assign w_size_dim = {{(DIM_W-7){1'b0}}, r_size};

    // One extra bit keeps the remaining-extent and end-of-tile sums exact.
    assign w_rem_w  = {1'b0, i_img_w} - {1'b0, r_x};
    assign w_rem_h  = {1'b0, i_img_h} - {1'b0, r_y};
    assign w_x_end  = {1'b0, r_x} + w_size_ext;
    assign w_y_end  = {1'b0, r_y} + w_size_ext;
    assign w_x_edge = w_x_end >= {1'b0, i_img_w};
    assign w_y_edge = w_y_end >= {1'b0, i_img_h};

    assign o_x    = r_x;
    assign o_y    = r_y;
    assign o_w    = (w_rem_w >= w_size_ext) ? r_size : w_rem_w[6:0];
    assign o_h    = (w_rem_h >= w_size_ext) ? r_size : w_rem_h[6:0];
    assign o_last = w_x_edge && w_y_edge;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x    <= '0;
            r_y    <= '0;
            r_size <= '0;
        end else if (i_init) begin
            r_x    <= '0;
            r_y    <= '0;
            r_size <= 7'd1 << i_size_log2;
        end else if (i_step) begin
            if (w_x_edge) begin
                r_x <= '0;
                r_y <= r_y + w_size_dim;
            end else begin
                r_x <= r_x + w_size_dim;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/impix_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : impix_tile_sequencer
// Description : CSR-controlled tile command sequencer with completion credits.
// Revision    : 1.0 - initial release
// ============================================================================
module impix_tile_sequencer #(
    parameter int DIM_W   = 12,
    parameter int MAX_OUT = 4
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [2:0]       avs_address,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    input  logic             avs_read,
    output logic [31:0]      avs_readdata,
    input  logic [3:0]       sw_in,
    output logic [3:0]       ind_out,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [DIM_W-1:0] cmd_x,
    output logic [DIM_W-1:0] cmd_y,
    output logic [6:0]       cmd_w,
    output logic [6:0]       cmd_h,
    output logic             cmd_last,
    input  logic             done_pulse,
    output logic             irq
);
    import impix_pkg::*;

    localparam logic [3:0] c_MAX_OUT = 4'(MAX_OUT);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DIM_W-1:0] r_img_w;
    logic [DIM_W-1:0] r_img_h;
    logic [2:0]       r_blk;
    logic             r_use_sw;
    logic             r_irq_en;
    logic             r_done;
    logic             r_aborted;
    logic             r_err;
    logic             r_abort_pend;
    logic [31:0]      r_tiles_done;
    logic [3:0]       r_out_cnt;
    logic [31:0]      r_readdata;
    logic [3:0]       r_ind;
    logic [3:0]       r_sw_meta;
    logic [3:0]       r_sw_sync;

    logic             w_ctrl_wr;
    logic             w_abort;
    logic             w_start;
    logic             w_busy;
    logic             w_zero_img;
    logic             w_hs;
    logic             w_done_acc;
    logic             w_stray;
    logic             w_frame_init;
    logic             w_last;
    logic [2:0]       w_eff_log2;
    logic             w_sw_unused;

    assign w_ctrl_wr    = avs_write && (avs_address == c_ADDR_CTRL);
    assign w_abort      = w_ctrl_wr && avs_writedata[c_CTRL_ABORT];
    assign w_start      = w_ctrl_wr && avs_writedata[c_CTRL_START] && !w_abort;
    assign w_busy       = (r_state != ST_IDLE);
    assign w_zero_img   = (r_img_w == '0) || (r_img_h == '0);
    assign w_hs         = cmd_valid && cmd_ready;
    assign w_done_acc   = done_pulse && (r_out_cnt != '0);
    assign w_stray      = done_pulse && (r_out_cnt == '0);
    assign w_frame_init = (r_state == ST_SETUP) ||
                          ((r_state == ST_IDLE) && w_start && w_zero_img);
    assign w_eff_log2   = r_use_sw ? clamp_log2({29'd0, r_sw_sync[2:0]}) : r_blk;
    assign w_sw_unused  = r_sw_sync[3];

    assign cmd_last     = w_last && cmd_valid;
    assign avs_readdata = r_readdata;
    assign ind_out      = r_ind;
    assign irq          = r_irq_en && (r_done || r_aborted || r_err);

    impix_tile_walker #(
        .DIM_W (DIM_W)
    ) u_walker (
        .clk         (clk_clk),
        .rst_n       (reset_reset_n),
        .i_init      (r_state == ST_SETUP),
        .i_step      (w_hs),
        .i_size_log2 (w_eff_log2),
        .i_img_w     (r_img_w),
        .i_img_h     (r_img_h),
        .o_x         (cmd_x),
        .o_y         (cmd_y),
        .o_w         (cmd_w),
        .o_h         (cmd_h),
        .o_last      (w_last)
    );

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // An abort leaves ISSUE immediately; a handshake in that same cycle still counts.
    always_comb begin
        w_state_nxt = r_state;
        cmd_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start)
                    w_state_nxt = w_zero_img ? ST_DONE : ST_SETUP;
            end
            ST_SETUP: begin
                w_state_nxt = w_abort ? ST_DRAIN : ST_ISSUE;
            end
            ST_ISSUE: begin
                cmd_valid = (r_out_cnt < c_MAX_OUT);
                if (w_abort || (cmd_valid && cmd_ready && w_last))
                    w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (r_out_cnt == '0)
                    w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_img_w      <= '0;
            r_img_h      <= '0;
            r_blk        <= 3'd3;
            r_use_sw     <= 1'b0;
            r_irq_en     <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_err        <= 1'b0;
            r_abort_pend <= 1'b0;
            r_tiles_done <= '0;
            r_out_cnt    <= '0;
        end else begin
            if (avs_write) begin
                case (avs_address)
                    c_ADDR_CTRL: begin
                        r_irq_en <= avs_writedata[c_CTRL_IRQ_EN];
                        if (!w_busy)
                            r_use_sw <= avs_writedata[c_CTRL_USE_SW];
                    end
                    c_ADDR_STATUS: begin
                        if (avs_writedata[c_STAT_DONE])    r_done    <= 1'b0;
                        if (avs_writedata[c_STAT_ABORTED]) r_aborted <= 1'b0;
                        if (avs_writedata[c_STAT_ERR])     r_err     <= 1'b0;
                    end
                    c_ADDR_IMG_W: if (!w_busy) r_img_w <= avs_writedata[DIM_W-1:0];
                    c_ADDR_IMG_H: if (!w_busy) r_img_h <= avs_writedata[DIM_W-1:0];
                    c_ADDR_BLK:   if (!w_busy) r_blk   <= clamp_log2(avs_writedata);
                    default: ;
                endcase
            end

            // Later assignments take priority: frame init, then completion, then error.
            if (w_frame_init) begin
                r_done       <= 1'b0;
                r_aborted    <= 1'b0;
                r_err        <= 1'b0;
                r_tiles_done <= '0;
            end
            if (r_state == ST_DONE) begin
                if (r_abort_pend)
                    r_aborted <= 1'b1;
                else
                    r_done <= 1'b1;
            end
            if (w_stray)
                r_err <= 1'b1;
            if (w_done_acc)
                r_tiles_done <= r_tiles_done + 32'd1;

            if (r_state == ST_DONE)
                r_abort_pend <= 1'b0;
            else if (w_abort && w_busy)
                r_abort_pend <= 1'b1;

            if (w_hs && !w_done_acc)
                r_out_cnt <= r_out_cnt + 4'd1;
            else if (!w_hs && w_done_acc)
                r_out_cnt <= r_out_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_readdata <= '0;
            r_ind      <= '0;
            r_sw_meta  <= '0;
            r_sw_sync  <= '0;
        end else begin
            r_sw_meta <= sw_in;
            r_sw_sync <= r_sw_meta;
            r_ind     <= {r_err, r_aborted, r_done, w_busy};
            if (avs_read) begin
                case (avs_address)
                    c_ADDR_CTRL:   r_readdata <= {28'd0, r_irq_en, r_use_sw, 2'b00};
                    c_ADDR_STATUS: r_readdata <= {28'd0, r_err, r_aborted, r_done, w_busy};
                    c_ADDR_IMG_W:  r_readdata <= {{(32-DIM_W){1'b0}}, r_img_w};
                    c_ADDR_IMG_H:  r_readdata <= {{(32-DIM_W){1'b0}}, r_img_h};
                    c_ADDR_BLK:    r_readdata <= {29'd0, r_blk};
                    c_ADDR_TILES:  r_readdata <= r_tiles_done;
                    c_ADDR_OUTST:  r_readdata <= {28'd0, r_out_cnt};
                    default:       r_readdata <= '0;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_impix_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_impix_tile_sequencer
// Description : Randomized self-checking bench with a tile-list reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_impix_tile_sequencer;

    localparam int c_DIM_W   = 12;
    localparam int c_MAX_OUT = 4;

    logic               clk_clk = 1'b0;
    logic               reset_reset_n;
    logic [2:0]         avs_address;
    logic               avs_write;
    logic [31:0]        avs_writedata;
    logic               avs_read;
    logic [31:0]        avs_readdata;
    logic [3:0]         sw_in;
    logic [3:0]         ind_out;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [c_DIM_W-1:0] cmd_x;
    logic [c_DIM_W-1:0] cmd_y;
    logic [6:0]         cmd_w;
    logic [6:0]         cmd_h;
    logic               cmd_last;
    logic               done_pulse;
    logic               irq;

    always #5 clk_clk = ~clk_clk;

    impix_tile_sequencer #(
        .DIM_W   (c_DIM_W),
        .MAX_OUT (c_MAX_OUT)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .avs_address   (avs_address),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_read      (avs_read),
        .avs_readdata  (avs_readdata),
        .sw_in         (sw_in),
        .ind_out       (ind_out),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_x         (cmd_x),
        .cmd_y         (cmd_y),
        .cmd_w         (cmd_w),
        .cmd_h         (cmd_h),
        .cmd_last      (cmd_last),
        .done_pulse    (done_pulse),
        .irq           (irq)
    );

    typedef struct {
        int x;
        int y;
        int w;
        int h;
        int last;
    } cmd_t;

    cmd_t got_q[$];
    int   due_q[$];
    int   cycle      = 0;
    int   ready_mode = 0;   // 0: always ready, 1: random, 2: never
    bit   auto_done  = 1'b0;
    bit   force_done = 1'b0;
    int   done_dly   = 3;
    int   model_out  = 0;
    int   errors     = 0;
    int   checks     = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int clamp_blk(input int v);
        return (v < 1) ? 1 : ((v > 6) ? 6 : v);
    endfunction

    // Runs at a negedge: decide this cycle's core-side inputs, log handshakes, advance.
    task automatic cyc();
        bit hs;
        bit acc;
        done_pulse = force_done;
        if (auto_done && due_q.size() > 0 && due_q[0] <= cycle) begin
            void'(due_q.pop_front());
            done_pulse = 1'b1;
        end
        case (ready_mode)
            0:       cmd_ready = 1'b1;
            1:       cmd_ready = 1'($urandom_range(0, 1));
            default: cmd_ready = 1'b0;
        endcase
        if (model_out >= c_MAX_OUT)
            chk("credit_valid", {31'd0, cmd_valid}, 32'd0);
        hs  = cmd_valid && cmd_ready;
        acc = done_pulse && (model_out > 0);
        if (hs) begin
            got_q.push_back('{x: int'(cmd_x), y: int'(cmd_y), w: int'(cmd_w),
                              h: int'(cmd_h), last: int'(cmd_last)});
            if (auto_done)
                due_q.push_back(cycle + done_dly);
        end
        model_out = model_out + int'(hs) - int'(acc);
        @(negedge clk_clk);
        cycle++;
    endtask

    task automatic csr_write(input logic [2:0] addr, input logic [31:0] data);
        avs_address   = addr;
        avs_writedata = data;
        avs_write     = 1'b1;
        cyc();
        avs_write     = 1'b0;
    endtask

    task automatic csr_read(input logic [2:0] addr, output logic [31:0] data);
        avs_address = addr;
        avs_read    = 1'b1;
        cyc();
        avs_read    = 1'b0;
        data        = avs_readdata;
    endtask

    task automatic wait_idle(input int budget);
        bit seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            cyc();
            if (ind_out[0])
                seen = 1'b1;
            else if (seen)
                break;
        end
        chk("idle_reached", {31'd0, seen && !ind_out[0]}, 32'd1);
    endtask

    task automatic setup_img(input int w, input int h, input int blk);
        csr_write(3'd2, w);
        csr_write(3'd3, h);
        csr_write(3'd4, blk);
    endtask

    // Reference: raster walk of an image in SxS tiles, clipped at the right/bottom edges.
    task automatic check_cmds(input int w, input int h, input int s);
        cmd_t exp_q[$];
        for (int ty = 0; ty < h; ty += s)
            for (int tx = 0; tx < w; tx += s)
                exp_q.push_back('{x: tx, y: ty,
                                  w: (s < w - tx) ? s : w - tx,
                                  h: (s < h - ty) ? s : h - ty,
                                  last: int'((tx + s >= w) && (ty + s >= h))});
        chk("n_cmds", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk("cmd_x", got_q[i].x, exp_q[i].x);
            chk("cmd_y", got_q[i].y, exp_q[i].y);
            chk("cmd_w", got_q[i].w, exp_q[i].w);
            chk("cmd_h", got_q[i].h, exp_q[i].h);
            chk("cmd_last", got_q[i].last, exp_q[i].last);
        end
    endtask

    task automatic run_frame(input int w, input int h, input int blk, input bit use_sw,
                             input logic [3:0] sw, input bit irq_en, input int rmode,
                             input int dly);
        logic [31:0] rd;
        int s;
        setup_img(w, h, blk);
        csr_read(3'd4, rd);
        chk("blk_clamp", rd, clamp_blk(blk));
        sw_in = sw;
        repeat (3) cyc();
        s = 1 << (use_sw ? clamp_blk(int'(sw[2:0])) : clamp_blk(blk));
        got_q.delete();
        due_q.delete();
        auto_done  = 1'b1;
        done_dly   = dly;
        ready_mode = rmode;
        csr_write(3'd0, {28'd0, irq_en, use_sw, 2'b01});
        wait_idle(40000);
        check_cmds(w, h, s);
        chk("ind_done", {28'd0, ind_out}, 32'h2);
        csr_read(3'd5, rd);
        chk("tiles_done", rd, got_q.size());
        csr_read(3'd1, rd);
        chk("status_done", rd, 32'h2);
        csr_read(3'd6, rd);
        chk("outst_zero", rd, 32'd0);
        chk("irq_level", {31'd0, irq}, {31'd0, irq_en});
        auto_done  = 1'b0;
        ready_mode = 0;
    endtask

    initial begin
        logic [31:0] rd;
        int w, h, blk, eff;
        logic [3:0] sw;
        bit use_sw;

        reset_reset_n = 1'b0;
        avs_address   = '0;
        avs_write     = 1'b0;
        avs_writedata = '0;
        avs_read      = 1'b0;
        sw_in         = '0;
        cmd_ready     = 1'b0;
        done_pulse    = 1'b0;
        @(negedge clk_clk);
        repeat (3) cyc();
        chk("rst_valid", {31'd0, cmd_valid}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_ind", {28'd0, ind_out}, 32'd0);
        chk("rst_rdata", avs_readdata, 32'd0);
        reset_reset_n = 1'b1;
        cyc();
        csr_read(3'd4, rd); chk("rst_blk", rd, 32'd3);
        csr_read(3'd2, rd); chk("rst_imgw", rd, 32'd0);
        csr_read(3'd1, rd); chk("rst_status", rd, 32'd0);
        csr_read(3'd6, rd); chk("rst_outst", rd, 32'd0);
        csr_read(3'd7, rd); chk("addr7_zero", rd, 32'd0);

        // 10x6 image, 4x4 tiles, always ready, completion 3 cycles after each command
        run_frame(10, 6, 2, 1'b0, 4'h0, 1'b0, 0, 3);

        // Credit limit with no completions
        setup_img(64, 64, 4);
        got_q.delete();
        csr_write(3'd0, 32'h1);
        repeat (20) cyc();
        chk("credit_hs", got_q.size(), c_MAX_OUT);
        chk("credit_stall", {31'd0, cmd_valid}, 32'd0);
        csr_read(3'd6, rd);
        chk("credit_outst", rd, c_MAX_OUT);
        force_done = 1'b1;
        cyc();
        force_done = 1'b0;
        repeat (10) cyc();
        chk("credit_one_more", got_q.size(), c_MAX_OUT + 1);
        auto_done = 1'b1;
        for (int i = 0; i < model_out; i++)
            due_q.push_back(cycle + 1 + i);
        wait_idle(4000);
        check_cmds(64, 64, 16);
        auto_done = 1'b0;

        // Abort while the third command is held by cmd_ready=0
        got_q.delete();
        ready_mode = 0;
        csr_write(3'd0, 32'h1);
        for (int g = 0; g < 50 && got_q.size() < 2; g++)
            cyc();
        ready_mode = 2;
        cyc();
        cyc();
        chk("held_valid", {31'd0, cmd_valid}, 32'd1);
        chk("held_x", {20'd0, cmd_x}, 32'd32);
        csr_write(3'd0, 32'hA);
        repeat (3) cyc();
        chk("abort_valid", {31'd0, cmd_valid}, 32'd0);
        chk("abort_hs", got_q.size(), 2);
        force_done = 1'b1;
        cyc();
        cyc();
        force_done = 1'b0;
        wait_idle(100);
        csr_read(3'd1, rd);
        chk("abort_status", rd, 32'h4);
        chk("abort_irq", {31'd0, irq}, 32'd1);
        csr_read(3'd5, rd);
        chk("abort_tiles", rd, 32'd2);
        csr_write(3'd1, 32'hE);
        cyc();
        chk("irq_cleared", {31'd0, irq}, 32'd0);

        // Handshake and completion in the same cycle
        got_q.delete();
        ready_mode = 2;
        csr_write(3'd0, 32'h1);
        cyc();
        ready_mode = 0;
        cyc();
        ready_mode = 2;
        cyc();
        ready_mode = 0;
        force_done = 1'b1;
        cyc();
        ready_mode = 2;
        force_done = 1'b0;
        csr_read(3'd6, rd);
        chk("hs_and_done", rd, 32'd1);
        chk("hs_and_done_cmds", got_q.size(), 2);
        csr_write(3'd0, 32'h2);
        force_done = 1'b1;
        cyc();
        force_done = 1'b0;
        wait_idle(100);
        ready_mode = 0;

        // Block size from switches, clamped to 64
        run_frame(100, 1, 2, 1'b1, 4'b0111, 1'b0, 0, 2);
        csr_write(3'd0, 32'h0);

        // Zero-width image completes with no commands
        setup_img(0, 5, 2);
        got_q.delete();
        csr_write(3'd0, 32'h1);
        cyc();
        csr_read(3'd1, rd);
        chk("zero_img_status", rd, 32'h2);
        chk("zero_img_cmds", got_q.size(), 0);
        csr_read(3'd5, rd);
        chk("zero_img_tiles", rd, 32'd0);

        // Stray completion while idle raises err; W1C clears it
        force_done = 1'b1;
        cyc();
        force_done = 1'b0;
        cyc();
        cyc();
        chk("stray_ind", {28'd0, ind_out}, 32'hA);
        csr_read(3'd1, rd);
        chk("stray_status", rd, 32'hA);
        csr_write(3'd1, 32'h8);
        csr_read(3'd1, rd);
        chk("err_w1c", rd, 32'h2);

        // Randomized frames
        for (int n = 0; n < 8; n++) begin
            blk    = $urandom_range(0, 9);
            use_sw = 1'($urandom_range(0, 1));
            sw     = 4'($urandom_range(0, 15));
            eff    = use_sw ? clamp_blk(int'(sw[2:0])) : clamp_blk(blk);
            w      = (eff <= 2) ? $urandom_range(1, 40) : $urandom_range(1, 130);
            h      = (eff <= 2) ? $urandom_range(1, 40) : $urandom_range(1, 130);
            run_frame(w, h, blk, use_sw, sw, 1'($urandom_range(0, 1)), 1,
                      $urandom_range(1, 8));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
